vga_rx_decoder: RTL and testbench
=================================

Name: vga_rx_decoder

Overview:
- Receiving end of the board's VGA output interface.
- Samples the active-low HS/VS/BLANK_N stream that the VGA timing generator drives, once per pixel strobe.
- Recovers the pixel column/row and checks line/frame geometry against the configured mode.
- Reports lock and sticky errors; used as an in-system monitor and as the checker for all pixel sources (testbars, tetris, game-of-life, snake).

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, pixel strobes per line (HS falling edge to HS falling edge)
- V_ACTIVE, 480, active lines per frame
- V_TOTAL, 525, lines (HS falling edges) per frame (VS falling edge to VS falling edge)
- LOCK_FRAMES, 2, consecutive good frames required to assert locked

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  one-cycle pixel strobe; all inputs below are sampled only when pix_en=1
- hs_n  in  1  horizontal sync, active low
- vs_n  in  1  vertical sync, active low
- blank_n  in  1  high during active video
- rgb  in  24  pixel data {R,G,B}; used only with the optional feature
- clear_err  in  1  synchronous clear of sticky error flags
- rx_col  out  11  column of the current active pixel
- rx_row  out  11  row of the current active pixel
- rx_valid  out  1  rx_col/rx_row valid for this pixel
- frame_start  out  1  one-cycle pulse on each VS falling edge
- locked  out  1  geometry matched for LOCK_FRAMES consecutive frames
- err_h  out  1  sticky: line length or active width mismatch
- err_v  out  1  sticky: frame line count or active height mismatch
- frame_crc  out  16  CRC of the last complete frame (optional feature)

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in SEARCH.
  - All counters 0.
  - Previous-sample registers hs/vs/blank = 1.
- Edge detection: compare each input with its value at the previous pix_en; no state changes when pix_en=0.
- Output latency: 1 clock after the sampling pix_en. Outputs hold between strobes; frame_start is high for exactly one clock.
- Column counter:
  - Cleared on blank_n rising edge; increments on every pix_en with blank_n=1.
  - rx_col = index of the sampled pixel (0 for the first pixel); rx_valid = sampled blank_n.
- Row counter:
  - Cleared on VS falling edge; increments on each blank_n falling edge.
  - rx_row = active lines completed before the current line.
- Line length: counts pix_en between HS falling edges, saturating at 2047. Each HS falling edge compares the count to H_TOTAL.
- Active width: each blank_n falling edge compares the column count to H_ACTIVE.
- Frame checks: each VS falling edge compares the HS-edge count to V_TOTAL and the active-line count to V_ACTIVE.
- FSM:
  - SEARCH: wait for a VS falling edge, then go to TRACK with good-frame count = 0. No checks run in SEARCH.
  - TRACK: checks active. Each VS falling edge with no mismatch in the frame increments the good-frame count; on reaching LOCKED_FRAMES → LOCKED and locked=1. Any mismatch → count reset to 0, stay in TRACK. Stickies are not set in TRACK.
  - LOCKED: any mismatch sets the matching sticky (err_h or err_v), clears locked, and → SEARCH.
- clear_err: clears err_h and err_v. If a new error occurs in the same cycle, the error wins.
- Simultaneous HS and VS falling edges: the HS edge is counted into the ending frame before the frame check.
- Reset mid-frame: immediate return to reset state; lock is re-acquired from the next VS falling edge.

Optional Feature:
- Macro: VGA_RX_CRC_EN.
- When defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF) over rgb of every active pixel, processed MSB first, 24 bits in one clock.
  - On each VS falling edge the value is latched to frame_crc and the CRC reinitialised.
- When undefined: no CRC logic; frame_crc tied to 0; rgb ignored.

Test Plan:
- 640x480 timing, pix_en every 2nd clock, 3 frames → locked=1 after the 2nd VS falling edge following the first; err_h=err_v=0.
- Locked stream, first active pixel of line 0 → rx_valid=1, rx_col=0, rx_row=0. Last pixel of the frame → rx_col=639, rx_row=479.
- While locked, one line shortened to 799 strobes → err_h=1, locked=0, FSM in SEARCH. Relock after 2 good frames; err_h stays 1 until clear_err.
- While locked, a frame with 524 lines → err_v=1, locked=0. Pulse clear_err → err_v=0 the next clock.
- Assert reset mid-line → all outputs 0 asynchronously; frame_start pulses on the next VS falling edge.
- With VGA_RX_CRC_EN and a constant 0x000000 frame → frame_crc equals the model's value at the frame end. Two identical frames give equal CRCs; a frame with one pixel flipped gives a different CRC.

Source files
------------

// File: rtl/vga_rx_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_rx_decoder_if
// Description : Bundle of the VGA receive stream, error-clear control and
//               the decoded column/row/status results.
//               master = stream source / status consumer, slave = decoder.
// Revision    : 1.0  initial release
// ============================================================================
interface vga_rx_decoder_if;
    logic        pix_en;
    logic        hs_n;
    logic        vs_n;
    logic        blank_n;
    logic [23:0] rgb;
    logic        clear_err;
    logic [10:0] rx_col;
    logic [10:0] rx_row;
    logic        rx_valid;
    logic        frame_start;
    logic        locked;
    logic        err_h;
    logic        err_v;
    logic [15:0] frame_crc;

    modport master (
        output pix_en, hs_n, vs_n, blank_n, rgb, clear_err,
        input  rx_col, rx_row, rx_valid, frame_start, locked, err_h, err_v, frame_crc
    );

    modport slave (
        input  pix_en, hs_n, vs_n, blank_n, rgb, clear_err,
        output rx_col, rx_row, rx_valid, frame_start, locked, err_h, err_v, frame_crc
    );
endinterface
`default_nettype wire

// File: rtl/vga_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module      : vga_rx_decoder
// Description : VGA stream receiver. Recovers pixel column/row from the
//               HS/VS/BLANK_N stream, checks line/frame geometry, reports lock
//               and sticky geometry errors. Optional per-frame CRC-16-CCITT of
//               the active pixels is enabled by defining VGA_RX_CRC_EN.
// Revision    : 1.0  initial release
// ============================================================================
module vga_rx_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  wire logic        CLOCK_50,
    input  wire logic        reset,
    vga_rx_decoder_if.slave  bus
);
    localparam logic [10:0] c_H_ACTIVE    = 11'(H_ACTIVE);
    localparam logic [10:0] c_H_TOTAL     = 11'(H_TOTAL);
    localparam logic [10:0] c_V_ACTIVE    = 11'(V_ACTIVE);
    localparam logic [10:0] c_V_TOTAL     = 11'(V_TOTAL);
    localparam logic [7:0]  c_LOCK_FRAMES = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d, blank_prev_q, blank_prev_d;
    logic [10:0] col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d;
    logic [10:0] line_cnt_q, line_cnt_d, hs_cnt_q, hs_cnt_d;
    logic [7:0]  good_cnt_q, good_cnt_d;
    logic        frame_bad_q, frame_bad_d;
    logic [10:0] rx_col_q, rx_col_d, rx_row_q, rx_row_d;
    logic        rx_valid_q, rx_valid_d, frame_start_q, frame_start_d;
    logic        locked_q, locked_d, err_h_q, err_h_d, err_v_q, err_v_d;

    logic        w_hs_fall, w_vs_fall, w_blank_rise, w_blank_fall;
    logic        w_h_mm, w_v_mm;
    logic [10:0] w_hs_cnt_end, w_rows_end;
    logic [7:0]  w_good_next;

    // Counters stick at all-ones so a dead or runaway stream cannot alias a
    // valid length after wrapping.
    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    assign w_hs_fall    = bus.pix_en &  hs_prev_q    & ~bus.hs_n;
    assign w_vs_fall    = bus.pix_en &  vs_prev_q    & ~bus.vs_n;
    assign w_blank_rise = bus.pix_en & ~blank_prev_q &  bus.blank_n;
    assign w_blank_fall = bus.pix_en &  blank_prev_q & ~bus.blank_n;

    // An HS edge coincident with the VS edge belongs to the frame that ends.
    assign w_hs_cnt_end = w_hs_fall    ? sat_inc(hs_cnt_q)  : hs_cnt_q;
    assign w_rows_end   = w_blank_fall ? sat_inc(row_cnt_q) : row_cnt_q;

    assign w_h_mm = (w_hs_fall & (line_cnt_q != c_H_TOTAL)) |
                    (w_blank_fall & (col_cnt_q != c_H_ACTIVE));
    assign w_v_mm = w_vs_fall & ((w_hs_cnt_end != c_V_TOTAL) | (w_rows_end != c_V_ACTIVE));

    assign w_good_next = good_cnt_q + 8'd1;

    // Edge history, position counters and per-pixel outputs, advanced per strobe.
    always_comb begin
        hs_prev_d     = hs_prev_q;
        vs_prev_d     = vs_prev_q;
        blank_prev_d  = blank_prev_q;
        col_cnt_d     = col_cnt_q;
        row_cnt_d     = row_cnt_q;
        line_cnt_d    = line_cnt_q;
        hs_cnt_d      = hs_cnt_q;
        rx_col_d      = rx_col_q;
        rx_row_d      = rx_row_q;
        rx_valid_d    = rx_valid_q;
        frame_start_d = w_vs_fall;
        if (bus.pix_en) begin
            hs_prev_d    = bus.hs_n;
            vs_prev_d    = bus.vs_n;
            blank_prev_d = bus.blank_n;
            line_cnt_d   = w_hs_fall ? 11'd1 : sat_inc(line_cnt_q);
            rx_valid_d   = bus.blank_n;
            rx_row_d     = row_cnt_q;
            if (bus.blank_n) begin
                if (w_blank_rise) begin
                    rx_col_d  = 11'd0;
                    col_cnt_d = 11'd1;
                end else begin
                    rx_col_d  = col_cnt_q;
                    col_cnt_d = sat_inc(col_cnt_q);
                end
            end
            if (w_vs_fall) begin
                row_cnt_d = 11'd0;
                hs_cnt_d  = 11'd0;
            end else begin
                if (w_blank_fall) row_cnt_d = sat_inc(row_cnt_q);
                if (w_hs_fall)    hs_cnt_d  = sat_inc(hs_cnt_q);
            end
        end
    end

    // Lock state machine and sticky error flags; a new error beats clear_err.
    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        frame_bad_d = frame_bad_q;
        err_h_d     = err_h_q;
        err_v_d     = err_v_q;
        if (bus.pix_en && bus.clear_err) begin
            err_h_d = 1'b0;
            err_v_d = 1'b0;
        end
        case (state_q)
            SEARCH: begin
                if (w_vs_fall) begin
                    state_d     = TRACK;
                    good_cnt_d  = 8'd0;
                    frame_bad_d = 1'b0;
                end
            end
            TRACK: begin
                if (w_h_mm) begin
                    good_cnt_d  = 8'd0;
                    frame_bad_d = 1'b1;
                end
                if (w_vs_fall) begin
                    frame_bad_d = 1'b0;
                    if (frame_bad_q || w_h_mm || w_v_mm) begin
                        good_cnt_d = 8'd0;
                    end else if (w_good_next >= c_LOCK_FRAMES) begin
                        state_d    = LOCKED;
                        good_cnt_d = 8'd0;
                    end else begin
                        good_cnt_d = w_good_next;
                    end
                end
            end
            LOCKED: begin
                if (w_h_mm || w_v_mm) begin
                    if (w_h_mm) err_h_d = 1'b1;
                    if (w_v_mm) err_v_d = 1'b1;
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
        locked_d = (state_d == LOCKED);
    end

    // State and datapath registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q       <= SEARCH;
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            blank_prev_q  <= 1'b1;
            col_cnt_q     <= 11'd0;
            row_cnt_q     <= 11'd0;
            line_cnt_q    <= 11'd0;
            hs_cnt_q      <= 11'd0;
            good_cnt_q    <= 8'd0;
            frame_bad_q   <= 1'b0;
            rx_col_q      <= 11'd0;
            rx_row_q      <= 11'd0;
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            err_h_q       <= 1'b0;
            err_v_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            blank_prev_q  <= blank_prev_d;
            col_cnt_q     <= col_cnt_d;
            row_cnt_q     <= row_cnt_d;
            line_cnt_q    <= line_cnt_d;
            hs_cnt_q      <= hs_cnt_d;
            good_cnt_q    <= good_cnt_d;
            frame_bad_q   <= frame_bad_d;
            rx_col_q      <= rx_col_d;
            rx_row_q      <= rx_row_d;
            rx_valid_q    <= rx_valid_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            err_h_q       <= err_h_d;
            err_v_q       <= err_v_d;
        end
    end

    assign bus.rx_col      = rx_col_q;
    assign bus.rx_row      = rx_row_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.locked      = locked_q;
    assign bus.err_h       = err_h_q;
    assign bus.err_v       = err_v_q;

`ifdef VGA_RX_CRC_EN
    localparam logic [15:0] c_CRC_INIT = 16'hFFFF;

    logic [15:0] crc_q, crc_d, frame_crc_q, frame_crc_d;
    logic [15:0] w_crc_base;

    // CRC-16-CCITT (0x1021), one 24-bit pixel per clock, MSB first.
    function automatic logic [15:0] crc_px(input logic [15:0] c, input logic [23:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 23; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // A frame boundary publishes the running CRC and restarts it.
    assign w_crc_base = w_vs_fall ? c_CRC_INIT : crc_q;

    // Accumulate active pixels and latch the finished frame value.
    always_comb begin
        frame_crc_d = w_vs_fall ? crc_q : frame_crc_q;
        crc_d       = w_crc_base;
        if (bus.pix_en && bus.blank_n) crc_d = crc_px(w_crc_base, bus.rgb);
    end

    // CRC registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            crc_q       <= c_CRC_INIT;
            frame_crc_q <= 16'd0;
        end else begin
            crc_q       <= crc_d;
            frame_crc_q <= frame_crc_d;
        end
    end

    assign bus.frame_crc = frame_crc_q;
`else
    logic w_unused_rgb;
    assign w_unused_rgb  = ^bus.rgb;
    assign bus.frame_crc = 16'd0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_vga_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_rx_decoder
// Description : Self-checking bench for vga_rx_decoder on a reduced 16x8
//               geometry (24 strobes/line, 12 lines/frame), pix_en every 2nd
//               clock. Frame scenarios come from a table; per-pixel results
//               go through a scoreboard queue. Honours VGA_RX_CRC_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vga_rx_decoder;
    localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_TOTAL = 24;
    localparam int V_ACTIVE = 8,  V_SYNC = 1, V_BP = 2, V_TOTAL = 12;
    localparam int V_FIRST  = V_SYNC + V_BP;
    localparam int K_NORMAL = 0, K_SHORT_LINE = 1, K_SHORT_FRAME = 2, K_FLIP = 3, K_RESET = 4;
    localparam int N_FRAMES = 17;

    typedef struct {
        int kind;
        bit do_clear;
        bit exp_locked;
        bit exp_err_h;
        bit exp_err_v;
    } frame_vec_t;

    typedef struct {
        bit          valid;
        bit          fs;
        logic [10:0] col;
        logic [10:0] row;
    } sb_item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_rx_decoder_if bus ();

    vga_rx_decoder #(
        .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE),
        .V_TOTAL(V_TOTAL), .LOCK_FRAMES(2)
    ) dut (
        .CLOCK_50(clk),
        .reset   (rst),
        .bus     (bus)
    );

    frame_vec_t  vecs [N_FRAMES];
    sb_item_t    sb_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          sb_en;
    bit          prev_vs_m;
    logic [15:0] crc_run_m, crc_frame_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [23:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 23; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [15:0] exp_crc();
`ifdef VGA_RX_CRC_EN
        return crc_frame_m;
`else
        return 16'd0;
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " rx_col"},      32'(bus.rx_col),      32'd0);
        check({tag, " rx_row"},      32'(bus.rx_row),      32'd0);
        check({tag, " rx_valid"},    32'(bus.rx_valid),    32'd0);
        check({tag, " frame_start"}, 32'(bus.frame_start), 32'd0);
        check({tag, " locked"},      32'(bus.locked),      32'd0);
        check({tag, " err_h"},       32'(bus.err_h),       32'd0);
        check({tag, " err_v"},       32'(bus.err_v),       32'd0);
        check({tag, " frame_crc"},   32'(bus.frame_crc),   32'd0);
    endtask

    // One pixel strobe: drive, record expectation, compare one clock later.
    task automatic strobe(input int v, input int h, input logic hs_n, input logic vs_n,
                          input logic blank_n, input logic [23:0] rgb, input bit clr);
        sb_item_t it, got;
        @(negedge clk);
        bus.pix_en = 1'b1; bus.hs_n = hs_n; bus.vs_n = vs_n;
        bus.blank_n = blank_n; bus.rgb = rgb; bus.clear_err = clr;
        it.valid  = blank_n;
        it.fs     = prev_vs_m & ~vs_n;
        it.col    = 11'(h);
        it.row    = 11'(v - V_FIRST);
        prev_vs_m = vs_n;
        if (it.fs) begin
            crc_frame_m = crc_run_m;
            crc_run_m   = 16'hFFFF;
        end
        if (blank_n) crc_run_m = crc_ref(crc_run_m, rgb);
        if (sb_en) sb_q.push_back(it);
        @(negedge clk);
        bus.pix_en = 1'b0; bus.clear_err = 1'b0;
        if (sb_q.size() > 0) begin
            got = sb_q.pop_front();
            check($sformatf("v%0d h%0d rx_valid", v, h), 32'(bus.rx_valid), 32'(got.valid));
            check($sformatf("v%0d h%0d frame_start", v, h), 32'(bus.frame_start), 32'(got.fs));
            if (got.valid) begin
                check($sformatf("v%0d h%0d rx_col", v, h), 32'(bus.rx_col), 32'(got.col));
                check($sformatf("v%0d h%0d rx_row", v, h), 32'(bus.rx_row), 32'(got.row));
            end
        end
    endtask

    task automatic mid_reset();
        #2 rst = 1'b1;
        #1 check_all_zero("mid reset");
        sb_en = 1'b0; prev_vs_m = 1'b1; crc_run_m = 16'hFFFF; crc_frame_m = 16'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic gen_line(input int v, input int len, input bit flip, input bit do_rst, input bit clr);
        for (int h = 0; h < len; h++) begin
            logic bl, hs, vs;
            logic [23:0] px;
            bl = (v >= V_FIRST) && (v < V_FIRST + V_ACTIVE) && (h < H_ACTIVE);
            hs = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
            vs = !(v < V_SYNC);
            px = (flip && v == V_FIRST + 2 && h == 7) ? 24'h000001 : 24'h000000;
            strobe(v, h, hs, vs, bl, px, clr && h == 0);
            if (clr && h == 0) begin
                check($sformatf("clear_err v%0d err_h", v), 32'(bus.err_h), 32'd0);
                check($sformatf("clear_err v%0d err_v", v), 32'(bus.err_v), 32'd0);
            end
            if (do_rst && v == 4 && h == 5) mid_reset();
        end
    endtask

    task automatic gen_frame(input int idx);
        frame_vec_t fv;
        fv    = vecs[idx];
        sb_en = 1'b1;
        for (int v = 0; v < V_TOTAL; v++) begin
            if (fv.kind == K_SHORT_FRAME && v == V_SYNC) continue;
            gen_line(v, (fv.kind == K_SHORT_LINE && v == 5) ? H_TOTAL - 1 : H_TOTAL,
                     fv.kind == K_FLIP, fv.kind == K_RESET, fv.do_clear && v == 0);
        end
        check($sformatf("f%0d locked", idx),    32'(bus.locked),    32'(fv.exp_locked));
        check($sformatf("f%0d err_h", idx),     32'(bus.err_h),     32'(fv.exp_err_h));
        check($sformatf("f%0d err_v", idx),     32'(bus.err_v),     32'(fv.exp_err_v));
        check($sformatf("f%0d frame_crc", idx), 32'(bus.frame_crc), 32'(exp_crc()));
    endtask

    initial begin
        // kind, clear_err at frame start, expected locked/err_h/err_v at frame end
        vecs[0]  = '{K_NORMAL,      1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{K_NORMAL,      1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{K_NORMAL,      1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{K_SHORT_LINE,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{K_NORMAL,      1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{K_FLIP,        1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{K_NORMAL,      1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{K_NORMAL,      1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{K_SHORT_FRAME, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{K_NORMAL,      1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{K_NORMAL,      1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{K_NORMAL,      1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{K_NORMAL,      1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{K_RESET,       1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{K_NORMAL,      1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{K_NORMAL,      1'b0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{K_NORMAL,      1'b0, 1'b1, 1'b0, 1'b0};

        bus.pix_en = 1'b0; bus.hs_n = 1'b1; bus.vs_n = 1'b1; bus.blank_n = 1'b0;
        bus.rgb = 24'd0; bus.clear_err = 1'b0;
        sb_en = 1'b1; prev_vs_m = 1'b1; crc_run_m = 16'hFFFF; crc_frame_m = 16'd0;
        repeat (3) @(negedge clk);
        check_all_zero("in reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after reset");

        // Lead-in blank line so the first VS edge follows a full-length line.
        gen_line(V_TOTAL - 1, H_TOTAL, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < N_FRAMES; i++) gen_frame(i);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
